// File: rtl/boot_loader.sv
// boot_loader
//
// Boot-time program loader between a UART receive byte stream and the QSPI
// SRAM bus. While loading it holds the CPU in reset, parses a frame
// (SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes[, CHK]) and writes the
// payload into SRAM starting at address 0x0000. When the image is complete
// it releases the CPU and becomes a transparent mux from the cache-side bus
// to the SRAM bus until the next reset.
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN
//   defined   : a trailing CHK byte (XOR of all payload bytes) is expected;
//               a mismatch ends in the error state.
//   undefined : no CHK byte; the image is accepted as soon as the last
//               payload write completes (or right after LEN_HI when LEN==0),
//               and the error state is only reachable by timeout.
//
// Parameters
//   TIMEOUT_CYC  inter-byte timeout in CLK cycles once a frame has started
//                (legal 2..2^24-1)
//   SYNC_BYTE    frame header value
//
// Ports
//   CLK, RES_N                 clock, synchronous active-low reset
//   RX_VALID/RX_DATA/RX_READY  UART receive byte handshake
//   CPU_RES_N                  CPU/cache reset, released on successful load
//   C_BUS_*                    cache-side bus (request in, RDATA/RDY out)
//   M_BUS_*                    SRAM-controller bus (request out, RDATA/RDY in)
//   LOAD_BUSY                  a frame is in progress (LEN_LO through CHK)
//   LOAD_ERR                   last frame failed; cleared by the next SYNC_BYTE

module boot_loader #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        RX_VALID,
    input  logic [7:0]  RX_DATA,
    output logic        RX_READY,
    output logic        CPU_RES_N,
    input  logic        C_BUS_REQ,
    input  logic        C_BUS_WRITE,
    input  logic [15:0] C_BUS_ADDR,
    input  logic [7:0]  C_BUS_WDATA,
    output logic [7:0]  C_BUS_RDATA,
    output logic        C_BUS_RDY,
    output logic        M_BUS_REQ,
    output logic        M_BUS_WRITE,
    output logic [15:0] M_BUS_ADDR,
    output logic [7:0]  M_BUS_WDATA,
    input  logic [7:0]  M_BUS_RDATA,
    input  logic        M_BUS_RDY,
    output logic        LOAD_BUSY,
    output logic        LOAD_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WR,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    // Where the frame goes once the payload is finished.
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t ST_PAYLOAD_DONE = ST_CHK;
`else
    localparam state_t ST_PAYLOAD_DONE = ST_RUN;
`endif

    // Control state (reset)
    state_t      state_q;
    state_t      state_next;
    logic        run_q;
    logic        err_q;
    logic [23:0] tmo_cnt_q;

    // Datapath state (no reset; always loaded before use)
    logic [7:0]  len_lo_q;
    logic [7:0]  byte_q;
    logic [15:0] remain_q;
    logic [15:0] addr_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        accept;
    logic        timed;
    logic        tmo_hit;
    logic        last_wr;
    logic [15:0] len_full;

    assign RX_READY = (state_q != ST_WR) && (state_q != ST_RUN);
    assign accept   = RX_VALID && RX_READY;
    assign len_full = {RX_DATA, len_lo_q};
    assign last_wr  = (remain_q == 16'd1);

    // The timeout only runs while the loader is waiting for a frame byte.
    assign timed    = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK};

    // Fires on the edge at which the idle counter would reach TIMEOUT_CYC-1.
    assign tmo_hit  = timed && !accept && (tmo_cnt_q == TIMEOUT_CYC - 24'd2);

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (accept && (RX_DATA == SYNC_BYTE)) begin
                    state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    state_next = (len_full == 16'd0) ? ST_PAYLOAD_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                if (M_BUS_RDY) begin
                    state_next = last_wr ? ST_PAYLOAD_DONE : ST_DATA;
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_next = (RX_DATA == xor_q) ? ST_RUN : ST_ERR;
                end
            end
`endif
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (tmo_hit) begin
            state_next = ST_ERR;
        end
    end

    // Control register stage. run_q/err_q are registered copies of the
    // next state so CPU_RES_N and LOAD_ERR come straight from flops.
    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q <= state_next;
            run_q   <= (state_next == ST_RUN);
            err_q   <= (state_next == ST_ERR);
            if (!timed || accept || tmo_hit) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 24'd1;
            end
        end
    end

    // Datapath register stage: length, write address/data and checksum.
    always_ff @(posedge CLK) begin
        if ((state_q == ST_LEN_LO) && accept) begin
            len_lo_q <= RX_DATA;
        end
        if ((state_q == ST_LEN_HI) && accept) begin
            remain_q <= len_full;
            addr_q   <= 16'h0000;
`ifdef BOOT_LOADER_CHECKSUM_EN
            xor_q    <= 8'h00;
`endif
        end
        if ((state_q == ST_DATA) && accept) begin
            byte_q <= RX_DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
            xor_q  <= xor_q ^ RX_DATA;
`endif
        end
        if ((state_q == ST_WR) && M_BUS_RDY) begin
            addr_q   <= addr_q + 16'd1;
            remain_q <= remain_q - 16'd1;
        end
    end

    // Bus mux: cache passthrough in RUN, loader write in WR, idle otherwise.
    always_comb begin
        M_BUS_REQ   = 1'b0;
        M_BUS_WRITE = 1'b0;
        M_BUS_ADDR  = 16'h0000;
        M_BUS_WDATA = 8'h00;
        if (run_q) begin
            M_BUS_REQ   = C_BUS_REQ;
            M_BUS_WRITE = C_BUS_WRITE;
            M_BUS_ADDR  = C_BUS_ADDR;
            M_BUS_WDATA = C_BUS_WDATA;
        end else if (state_q == ST_WR) begin
            M_BUS_REQ   = 1'b1;
            M_BUS_WRITE = 1'b1;
            M_BUS_ADDR  = addr_q;
            M_BUS_WDATA = byte_q;
        end
    end

    assign C_BUS_RDATA = run_q ? M_BUS_RDATA : 8'h00;
    assign C_BUS_RDY   = run_q && M_BUS_RDY;
    assign CPU_RES_N   = run_q;
    assign LOAD_ERR    = err_q;
    assign LOAD_BUSY   = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WR, ST_CHK};

endmodule
